debug_host: RTL and testbench

DEBUG_HOST -- requirements
Module: debug_host

---
 rtl/debug_host.sv | 174 +++++++++++++++++
 tb/tb_debug_host.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_host.sv
// debug_host: drives a debug session over a byte-wide UART FIFO pair.
//   Sends a load command (0x4C), streams program words MSB-first, sends the
//   run command, then collects a DUMP_WORDS-word dump frame from the RX FIFO.
// Ports:
//   i_clk, i_reset (sync, active low)
//   i_start, i_run_cmd                        session request and run byte
//   i_ins_valid/i_ins/i_ins_last/o_ins_ready  instruction source handshake
//   i_uart_rx_empty/i_uart_tx_full/i_uart_data_rd, o_uart_rd/o_uart_wr/o_uart_data_wr
//   o_dump_valid/o_dump_data/o_dump_index     one strobe per dump word
//   o_busy/o_done/o_error                     session status
module debug_host #(
    parameter int UART_BUS_SIZE  = 8,
    parameter int WORD_SIZE      = 32,
    parameter int DUMP_WORDS     = 64,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic [UART_BUS_SIZE-1:0]      i_run_cmd,
    input  logic                          i_ins_valid,
    input  logic [WORD_SIZE-1:0]          i_ins,
    input  logic                          i_ins_last,
    output logic                          o_ins_ready,
    input  logic                          i_uart_rx_empty,
    input  logic                          i_uart_tx_full,
    input  logic [UART_BUS_SIZE-1:0]      i_uart_data_rd,
    output logic                          o_uart_rd,
    output logic                          o_uart_wr,
    output logic [UART_BUS_SIZE-1:0]      o_uart_data_wr,
    output logic                          o_dump_valid,
    output logic [WORD_SIZE-1:0]          o_dump_data,
    output logic [$clog2(DUMP_WORDS)-1:0] o_dump_index,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_error
);
    localparam int BPW   = WORD_SIZE / UART_BUS_SIZE;
    localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int IDX_W = $clog2(DUMP_WORDS);
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [BC_W-1:0]          BC_LAST  = BC_W'(BPW - 1);
    localparam logic [IDX_W-1:0]         IDX_LAST = IDX_W'(DUMP_WORDS - 1);
    localparam logic [TO_W-1:0]          TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [UART_BUS_SIZE-1:0] LOAD_CMD = UART_BUS_SIZE'(8'h4C);

    typedef enum logic [2:0] {
        IDLE, SEND_LOAD, SEND_INS, SEND_RUN, RECV_DUMP, DONE, ERROR
    } state_t;

    state_t                               state;
    logic [UART_BUS_SIZE-1:0]             run_cmd;
    logic [WORD_SIZE-1:0]                 tx_sh;     // word being serialized, next byte on top
    logic                                 tx_have;
    logic                                 tx_last;
    logic [BC_W-1:0]                      tx_cnt;
    logic [BC_W-1:0]                      rx_cnt;
    logic [WORD_SIZE-UART_BUS_SIZE-1:0]   rx_acc;    // bytes of the word received so far
    logic [IDX_W-1:0]                     word_cnt;
    logic                                 rx_all;    // last word captured, strobe pending
    logic [TO_W-1:0]                      idle_cnt;
    logic                                 push_en;
    logic [WORD_SIZE-1:0]                 rx_word;

    // FIFO strobes are combinational from the registered state so that the
    // push/pop lands in the very cycle the FIFO status allows it.
    assign push_en      = (state == SEND_LOAD) || (state == SEND_RUN) ||
                          (state == SEND_INS && tx_have);
    assign o_uart_wr    = push_en && !i_uart_tx_full;
    assign o_uart_rd    = (state == RECV_DUMP) && !rx_all && !i_uart_rx_empty;
    assign o_ins_ready  = (state == SEND_INS) && !tx_have;
    assign o_busy       = (state == SEND_LOAD) || (state == SEND_INS) ||
                          (state == SEND_RUN)  || (state == RECV_DUMP);
    assign o_done       = (state == DONE);
    assign o_error      = (state == ERROR);
    assign rx_word      = {rx_acc, i_uart_data_rd};

    always_comb begin
        o_uart_data_wr = '0;
        case (state)
            SEND_LOAD: o_uart_data_wr = LOAD_CMD;
            SEND_INS:  if (tx_have) o_uart_data_wr = tx_sh[WORD_SIZE-1 -: UART_BUS_SIZE];
            SEND_RUN:  o_uart_data_wr = run_cmd;
            default:   o_uart_data_wr = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state        <= IDLE;
            run_cmd      <= '0;
            tx_sh        <= '0;
            tx_have      <= 1'b0;
            tx_last      <= 1'b0;
            tx_cnt       <= '0;
            rx_cnt       <= '0;
            rx_acc       <= '0;
            word_cnt     <= '0;
            rx_all       <= 1'b0;
            idle_cnt     <= '0;
            o_dump_valid <= 1'b0;
            o_dump_data  <= '0;
            o_dump_index <= '0;
        end else begin
            o_dump_valid <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (i_start) begin
                        state    <= SEND_LOAD;
                        run_cmd  <= i_run_cmd;
                        tx_have  <= 1'b0;
                        tx_cnt   <= '0;
                        rx_cnt   <= '0;
                        word_cnt <= '0;
                        idle_cnt <= '0;
                        rx_all   <= 1'b0;
                    end
                end
                SEND_LOAD: if (!i_uart_tx_full) state <= SEND_INS;
                SEND_INS: begin
                    if (!tx_have) begin
                        // ready is high here, so valid alone completes the transfer
                        if (i_ins_valid) begin
                            tx_sh   <= i_ins;
                            tx_last <= i_ins_last;
                            tx_have <= 1'b1;
                            tx_cnt  <= '0;
                        end
                    end else if (!i_uart_tx_full) begin
                        tx_sh <= tx_sh << UART_BUS_SIZE;
                        if (tx_cnt == BC_LAST) begin
                            tx_have <= 1'b0;
                            tx_cnt  <= '0;
                            if (tx_last) state <= SEND_RUN;
                        end else begin
                            tx_cnt <= tx_cnt + 1'b1;
                        end
                    end
                end
                SEND_RUN: begin
                    if (!i_uart_tx_full) begin
                        state    <= RECV_DUMP;
                        idle_cnt <= '0;
                    end
                end
                RECV_DUMP: begin
                    if (rx_all) begin
                        // final strobe is on the outputs this cycle
                        state <= DONE;
                    end else if (o_uart_rd) begin
                        idle_cnt <= '0;
                        rx_acc   <= rx_word[WORD_SIZE-UART_BUS_SIZE-1:0];
                        if (rx_cnt == BC_LAST) begin
                            rx_cnt       <= '0;
                            o_dump_valid <= 1'b1;
                            o_dump_data  <= rx_word;
                            o_dump_index <= word_cnt;
                            word_cnt     <= word_cnt + 1'b1;
                            if (word_cnt == IDX_LAST) rx_all <= 1'b1;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end else if (idle_cnt == TO_LAST) begin
                        state <= ERROR;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_debug_host.sv
module tb_debug_host;
    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_start = 1'b0;
    logic [7:0]  i_run_cmd = 8'h00;
    logic        i_ins_valid = 1'b0;
    logic [31:0] i_ins = 32'h0;
    logic        i_ins_last = 1'b0;
    logic        o_ins_ready;
    logic        i_uart_rx_empty = 1'b1;
    logic        i_uart_tx_full = 1'b0;
    logic [7:0]  i_uart_data_rd = 8'h00;
    logic        o_uart_rd, o_uart_wr;
    logic [7:0]  o_uart_data_wr;
    logic        o_dump_valid;
    logic [31:0] o_dump_data;
    logic [0:0]  o_dump_index;
    logic        o_busy, o_done, o_error;

    always #5 i_clk = ~i_clk;

    debug_host #(.UART_BUS_SIZE(8), .WORD_SIZE(32), .DUMP_WORDS(2), .TIMEOUT_CYCLES(50)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_run_cmd(i_run_cmd),
        .i_ins_valid(i_ins_valid), .i_ins(i_ins), .i_ins_last(i_ins_last), .o_ins_ready(o_ins_ready),
        .i_uart_rx_empty(i_uart_rx_empty), .i_uart_tx_full(i_uart_tx_full), .i_uart_data_rd(i_uart_data_rd),
        .o_uart_rd(o_uart_rd), .o_uart_wr(o_uart_wr), .o_uart_data_wr(o_uart_data_wr),
        .o_dump_valid(o_dump_valid), .o_dump_data(o_dump_data), .o_dump_index(o_dump_index),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    int total = 0;
    int bad = 0;
    int viol = 0;
    int cyc = 0;
    int last_pop = 0;
    int stall_at = -1;
    int stall_left = 0;
    int stall_cyc = 0;
    int stall_rdy = 0;
    bit pop_pend = 1'b0;
    logic [7:0]  push_q[$];
    logic [7:0]  rx_q[$];
    logic [32:0] dump_q[$];

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        bit          two;
        logic [7:0]  cmd;
        int          stall_at;
        bit          start_mid;
        logic [79:0] exp;
        int          nexp;
        logic [31:0] d0;
        logic [31:0] d1;
    } vec_t;
    vec_t vecs[3];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Observers: sampled at negedge, between the stimulus and the active edge.
    always @(negedge i_clk) begin
        if (o_uart_wr) begin
            if (i_uart_tx_full || !o_busy) viol++;
            push_q.push_back(o_uart_data_wr);
        end
        if (o_uart_rd && i_uart_rx_empty) viol++;
        pop_pend = o_uart_rd;
        if (o_dump_valid) dump_q.push_back({o_dump_index, o_dump_data});
        if (i_uart_tx_full) begin
            stall_cyc++;
            if (o_ins_ready) stall_rdy++;
        end
    end

    // RX FIFO model with show-ahead data.
    always @(posedge i_clk) begin
        cyc++;
        if (pop_pend && rx_q.size() > 0) begin
            void'(rx_q.pop_front());
            last_pop = cyc;
        end
        #2;
        i_uart_rx_empty = (rx_q.size() == 0);
        i_uart_data_rd  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end

    // TX FIFO full model: holds full for stall_left cycles once stall_at bytes were pushed.
    always @(posedge i_clk) begin
        #1;
        if (stall_left > 0 && push_q.size() == stall_at) begin
            i_uart_tx_full = 1'b1;
            stall_left--;
        end else begin
            i_uart_tx_full = 1'b0;
        end
    end

    task automatic start_session(input logic [7:0] cmd);
        @(negedge i_clk);
        i_run_cmd = cmd;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit last);
        int t = 0;
        i_ins_valid = 1'b1;
        i_ins = w;
        i_ins_last = last;
        while (!o_ins_ready && t < 200) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 200) chk("ins_ready_timeout", 1, 0);
        @(negedge i_clk);
        i_ins_valid = 1'b0;
    endtask

    task automatic wait_pushes(input int n);
        int t = 0;
        while (push_q.size() < n && t < 300) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 300) chk("push_wait_timeout", push_q.size(), n);
    endtask

    task automatic run_vec(input vec_t v);
        logic [79:0] got;
        int t;
        push_q.delete();
        dump_q.delete();
        stall_cyc = 0;
        stall_rdy = 0;
        stall_at = v.stall_at;
        stall_left = (v.stall_at >= 0) ? 10 : 0;
        start_session(v.cmd);
        send_word(v.w0, !v.two);
        if (v.two) send_word(v.w1, 1'b1);
        wait_pushes(v.nexp);
        got = '0;
        for (int i = 0; i < push_q.size() && i < 10; i++) got[79-8*i -: 8] = push_q[i];
        chk("push_count", push_q.size(), v.nexp);
        chk("push_bytes", got, v.exp);
        if (v.stall_at >= 0) begin
            chk("stall_cycles", stall_cyc, 10);
            chk("stall_ready_low", stall_rdy, 0);
        end
        @(negedge i_clk);
        chk("status_in_dump", {o_busy, o_done, o_error}, 3'b100);
        for (int b = 0; b < 4; b++) rx_q.push_back(v.d0[31-8*b -: 8]);
        for (int b = 0; b < 4; b++) rx_q.push_back(v.d1[31-8*b -: 8]);
        if (v.start_mid) begin
            repeat (3) @(negedge i_clk);
            i_run_cmd = 8'h99;
            i_start = 1'b1;
            @(negedge i_clk);
            i_start = 1'b0;
        end
        t = 0;
        while (!o_done && t < 100) begin
            @(negedge i_clk);
            t++;
        end
        chk("done_reached", {o_done, o_busy, o_error}, 3'b100);
        chk("dump_count", dump_q.size(), 2);
        if (dump_q.size() >= 2) begin
            chk("dump_word0", dump_q[0], {1'b0, v.d0});
            chk("dump_word1", dump_q[1], {1'b1, v.d1});
        end
        chk("push_count_after", push_q.size(), v.nexp);
    endtask

    function automatic logic [127:0] outs();
        return {o_uart_rd, o_uart_wr, o_ins_ready, o_dump_valid, o_busy, o_done, o_error,
                o_uart_data_wr, o_dump_data, o_dump_index};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n;
        vecs[0] = '{w0: 32'h20010005, w1: 32'h0, two: 1'b0, cmd: 8'h43, stall_at: -1, start_mid: 1'b0,
                    exp: 80'h4C2001000543_00000000, nexp: 6, d0: 32'h00000007, d1: 32'hDEADBEEF};
        vecs[1] = '{w0: 32'h12345678, w1: 32'hA5A5FF00, two: 1'b1, cmd: 8'h53, stall_at: -1, start_mid: 1'b1,
                    exp: 80'h4C12345678A5A5FF0053, nexp: 10, d0: 32'h01020304, d1: 32'hF0E0D0C0};
        vecs[2] = '{w0: 32'hCAFEBABE, w1: 32'h0, two: 1'b0, cmd: 8'h43, stall_at: 2, start_mid: 1'b0,
                    exp: 80'h4CCAFEBABE43_00000000, nexp: 6, d0: 32'h80000001, d1: 32'h7FFFFFFE};

        // reset state
        repeat (3) @(negedge i_clk);
        chk("reset_outputs", outs(), 0);
        i_reset = 1'b1;
        @(negedge i_clk);
        chk("idle_outputs", outs(), 0);

        foreach (vecs[k]) run_vec(vecs[k]);

        // dump timeout: three bytes then silence
        push_q.delete();
        dump_q.delete();
        start_session(8'h53);
        send_word(32'h11223344, 1'b1);
        wait_pushes(6);
        @(negedge i_clk);
        rx_q.push_back(8'hAA);
        rx_q.push_back(8'hBB);
        rx_q.push_back(8'hCC);
        t = 0;
        while ((rx_q.size() != 0 || o_uart_rd) && t < 50) begin
            @(negedge i_clk);
            t++;
        end
        t = 0;
        while (cyc < last_pop + 49 && t < 100) begin
            @(negedge i_clk);
            t++;
        end
        chk("no_error_at_49", {o_error, o_busy}, 2'b01);
        @(negedge i_clk);
        chk("error_at_50", {o_error, o_busy, o_done}, 3'b100);
        chk("timeout_no_dump", dump_q.size(), 0);

        // reset in the middle of SEND_INS
        push_q.delete();
        start_session(8'h43);
        i_ins_valid = 1'b1;
        i_ins = 32'hAABBCCDD;
        i_ins_last = 1'b1;
        t = 0;
        while (push_q.size() < 2 && t < 50) begin
            @(negedge i_clk);
            t++;
        end
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("midreset_outputs", outs(), 0);
        i_ins_valid = 1'b0;
        i_reset = 1'b1;
        n = push_q.size();
        repeat (5) @(negedge i_clk);
        chk("midreset_no_push", push_q.size(), n);
        chk("midreset_idle", outs(), 0);
        run_vec(vecs[1]);

        chk("illegal_fifo_ops", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
